// File: rtl/divu_seq.sv
/*--------------------------------------------------------------------------
 * divu_seq : sequential unsigned divider (restoring, 1 bit/cycle) with
 *            pipeline stall output. Option macro: DIVU_EARLY_EXIT_EN.
 * Revision : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module divu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             mf_req,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;   // shifts dividend out, quotient in
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   always_comb begin
      trial    = {rem_q, dvd_q[WIDTH-1]};
      diff     = trial - {1'b0, dvs_q};
      q_bit    = ~diff[WIDTH];
      // When the subtraction fails, trial < divisor so it fits in WIDTH bits.
      step_rem = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      step_quo = {dvd_q[WIDTH-2:0], q_bit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  hi_d    = dividend;
                  lo_d    = '1;
                  state_d = DONE;
               end
`ifdef DIVU_EARLY_EXIT_EN
               else if (dividend < divisor) begin
                  hi_d    = dividend;
                  lo_d    = '0;
                  state_d = DONE;
               end
`endif
               else begin
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               hi_d    = step_rem;
               lo_d    = step_quo;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy  = (state_q == BUSY);
   assign done  = (state_q == DONE);
   assign stall = busy & (mf_req | start);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_divu_seq.sv
/*--------------------------------------------------------------------------
 * tb_divu_seq : directed + random checks of divu_seq against an
 *               arithmetic reference model.
 * Revision    : 1.0
 *--------------------------------------------------------------------------*/
`default_nettype none

module tb_divu_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             mf_req;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int               n_vec = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] prev_hi = '0;
   logic [WIDTH-1:0] prev_lo = '0;

   divu_seq #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .mf_req   (mf_req),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (b == 0) return 1;
`ifdef DIVU_EARLY_EXIT_EN
      if (a < b) return 1;
`endif
      return WIDTH + 1;
   endfunction

   function automatic logic [WIDTH-1:0] ref_hi(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (b == 0) ? a : a % b;
   endfunction

   function automatic logic [WIDTH-1:0] ref_lo(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (b == 0) ? {WIDTH{1'b1}} : a / b;
   endfunction

   // Called in the sampling window of an IDLE or DONE cycle.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      mf_req   = 1'b0;
      #1;
      check("stall_at_issue", stall, 0);
   endtask

   // Follows one accepted division to its DONE cycle; optional mf_req from
   // cycle mf_at and a second start (a2/b2) held from cycle s2_at.
   task automatic track(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int mf_at, input int s2_at,
                        input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
      int lat;
      lat = exp_lat(a, b);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk);
         @(negedge clk);
         mf_req = (mf_at != 0) && (k >= mf_at);
         if ((s2_at != 0) && (k >= s2_at)) begin
            start    = 1'b1;
            dividend = a2;
            divisor  = b2;
         end else begin
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
         end
         #1;
         check("busy", busy, k < lat);
         check("done", done, k == lat);
         check("stall", stall, (k < lat) && (mf_req || start));
         if (k < lat) begin
            check("hi_hold", hi, prev_hi);
            check("lo_hold", lo, prev_lo);
         end else begin
            prev_hi = ref_hi(a, b);
            prev_lo = ref_lo(a, b);
            check("hi", hi, prev_hi);
            check("lo", lo, prev_lo);
         end
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      mf_req = 1'b0;
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_stall", stall, 0);
      check("idle_hi", hi, prev_hi);
      check("idle_lo", lo, prev_lo);
   endtask

   initial begin
      logic [WIDTH-1:0] a, b;
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      mf_req   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      rst   = 1'b0;
      start = 1'b0;
      #1;
      check("rst_stall", stall, 0);

      issue(32'd100, 32'd7);          track(32'd100, 32'd7, 0, 0, 0, 0);     idle_cycle();
      issue(32'hFFFF_FFFF, 32'd1);    track(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0); idle_cycle();
      issue(32'd55, 32'd0);           track(32'd55, 32'd0, 0, 0, 0, 0);      idle_cycle();
      issue(32'd100, 32'd7);          track(32'd100, 32'd7, 5, 0, 0, 0);     idle_cycle();

      // Second start arrives mid-division, is stalled, then taken in DONE.
      issue(32'd100, 32'd7);
      track(32'd100, 32'd7, 0, 10, 32'd40, 32'd6);
      track(32'd40, 32'd6, 0, 0, 0, 0);
      idle_cycle();

      // Reset mid-division, with start and mf_req also high on that edge.
      issue(32'd1000, 32'd3);
      for (int k = 1; k < 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         #1;
         check("pre_rst_busy", busy, 1);
      end
      @(posedge clk);
      @(negedge clk);
      rst    = 1'b1;
      start  = 1'b1;
      mf_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      #1;
      prev_hi = '0;
      prev_lo = '0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      mf_req = 1'b0;
      for (int k = 0; k < 36; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check("post_rst_done", done, 0);
      end

      issue(32'd5, 32'd9);            track(32'd5, 32'd9, 0, 0, 0, 0);       idle_cycle();

      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = $urandom_range(1, 15);
            2: begin b = $urandom | 32'h1; a = a % b; end
            default: b = $urandom;
         endcase
         issue(a, b);
         track(a, b, (n % 3 == 0) ? int'($urandom_range(1, 20)) : 0, 0, 0, 0);
         if (n % 2 == 0) idle_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
